ahb_burst_ram_subordinate: RTL
==============================

Name: ahb_burst_ram_subordinate

Overview:
- AHB-Lite subordinate (responder) fronting an on-chip RAM; the memory-side counterpart to the cache bus manager in the EBU.
- Services single transfers and the fixed-length INCR bursts the cache manager issues for line fills and writebacks.
- Programmable wait states on first (NONSEQ) and subsequent (SEQ) beats, byte strobes, and two-cycle ERROR response for out-of-range addresses.
- Used as the uncore RAM model and as the response model in EBU verification.

Parameters:
- AHBW, 64, data bus width in bits (32 or 64).
- PA_BITS, 34, HADDR width.
- BASE, 'h80000000, byte base address of RAM region.
- DEPTH, 4096, RAM size in AHBW-bit words (power of 2).
- NONSEQ_WAIT, 2, wait states inserted on a NONSEQ beat (0..15).
- SEQ_WAIT, 0, wait states inserted on a SEQ beat (0..15).

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset
- HSEL  in  1  subordinate select
- HADDR  in  PA_BITS  byte address (address phase)
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 write, 0 read
- HSIZE  in  3  transfer size (informational; HWSTRB governs writes)
- HBURST  in  3  burst type (informational; beat addresses taken from HADDR)
- HWDATA  in  AHBW  write data (data phase)
- HWSTRB  in  AHBW/8  byte enables (data phase)
- HREADY  in  1  bus-level ready; address phase accepted only when high
- HRDATA  out  AHBW  read data
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Clocking/reset: one clock, HCLK; reset is synchronous and active-high (HRESET). Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending write cleared. RAM contents are not reset.
- Address phase is accepted at a rising edge when HSEL & HREADY & HTRANS[1]. At that edge the block registers:
  - word index = (HADDR-BASE)>>log2(AHBW/8), modulo DEPTH;
  - HWRITE;
  - InRange = (BASE <= HADDR < BASE+DEPTH*AHBW/8);
  - beat type NONSEQ/SEQ.
- IDLE/BUSY, or HSEL=0, with HREADY high: no data phase follows; next cycle HREADYOUT=1, HRESP=0.
- States:
  - IDLE: no data phase pending; HREADYOUT=1.
  - WAIT: counter loaded with NONSEQ_WAIT or SEQ_WAIT at acceptance, decrements each cycle; HREADYOUT=0 while counter≠0. Enters DATA when counter reaches 0; a load value of 0 goes straight to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the beat completes this cycle. Next state is WAIT/DATA if a new address phase is accepted at this edge, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1; next state IDLE, or a new beat if accepted.
- Out-of-range beat: enters ERR1 directly, ignoring wait counts. No RAM access; HRDATA is held.
- Write: HWDATA/HWSTRB are sampled at the edge ending the DATA cycle. RAM bytes with HWSTRB[i]=1 are updated at that edge; other bytes are unchanged.
- Read: HRDATA is registered with RAM[index] at the edge entering DATA, so it is valid throughout the DATA cycle.
  - Forwarding: if a write completes at that same edge to the same index, HRDATA takes the merged bytes (new bytes where strobed, old elsewhere).
  - Between beats HRDATA holds its last value.
- Back-to-back pipelining: with NONSEQ_WAIT=SEQ_WAIT=0, one beat completes per cycle, and a 4-beat burst finishes in 4 data cycles after the first address phase.
- Index wraps modulo DEPTH. The top word of the region is in range; BASE+DEPTH*AHBW/8 is out of range.
- An address phase presented while HREADYOUT=0 is not accepted (HREADY low). The manager holds it and it is accepted at the ready edge.
- HRESET asserted mid-beat or mid-burst: the in-flight write is discarded (RAM unchanged), the FSM returns to IDLE, and HREADYOUT=1 on the cycle after reset.

Test Plan:
- Single write then read, NONSEQ_WAIT=2: write 'h1122334455667788 to 'h80000010 with HWSTRB='hFF, then read 'h80000010 -> HREADYOUT low 2 cycles each beat; read returns 'h1122334455667788 with HRESP=0.
- Byte strobes: RAM word 'hFFFFFFFFFFFFFFFF, write 'h00000000000000AB with HWSTRB='h01, then read -> 'hFFFFFFFFFFFFFFAB.
- INCR4 read burst at 'h80000100, NONSEQ_WAIT=2, SEQ_WAIT=0, words preloaded 0..3 -> data cycles at +3, +4, +5, +6 cycles from NONSEQ acceptance; HRDATA 0, 1, 2, 3.
- Write then immediate read of the same word, waits 0: write 'hDEAD with HWSTRB='h03, then read of the same address in the next address phase -> read returns the forwarded 'h...DEAD in the following cycle.
- Out-of-range read at BASE+DEPTH*8 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. The next in-range beat returns OKAY; RAM is untouched.
- HRESET asserted during the second wait cycle of a write to 'h80000020 (old value 'h5) -> the word still reads 'h5; HREADYOUT=1 and HRESP=0 the cycle after reset.

Source files
------------

// File: rtl/ahb_burst_ram_subordinate.sv
// AHB-Lite subordinate fronting an on-chip RAM.
// Single transfers and INCR bursts, programmable NONSEQ/SEQ wait states,
// byte-strobed writes, read-after-write forwarding, and a two-cycle ERROR
// response for addresses outside the RAM window.
module ahb_burst_ram_subordinate #(
  parameter int          AHBW        = 64,
  parameter int          PA_BITS     = 34,
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          NONSEQ_WAIT = 2,
  parameter int          SEQ_WAIT    = 0
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW/8-1:0]   HWSTRB,
  input  logic                HREADY,
  output logic [AHBW-1:0]     HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP
);

  localparam int BYTES = AHBW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  // Window bounds carry one extra bit so BASE + size cannot overflow.
  localparam logic [PA_BITS:0] LO = BASE[PA_BITS:0];
  localparam logic [PA_BITS:0] HI = LO + (PA_BITS+1)'(DEPTH * BYTES);

  localparam logic [3:0] NS_LOAD = 4'(NONSEQ_WAIT);
  localparam logic [3:0] SQ_LOAD = 4'(SEQ_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nxt;

  logic [IW-1:0]      idx_q;
  logic               write_q;

  logic [AHBW-1:0]    mem [DEPTH];

  logic [PA_BITS:0]   addr_x;
  logic [PA_BITS:0]   offset;
  logic [IW-1:0]      idx_a;
  logic               in_range_a;
  logic [3:0]         load_a;
  logic               accept;

  logic               wr_done;
  logic [IW-1:0]      rd_idx;
  logic               rd_write;
  logic               load_rd;
  logic [AHBW-1:0]    rd_word;
  logic [AHBW-1:0]    rd_val;

  logic               unused_ok;

  // Replace the strobed bytes of old_w with those of new_w.
  function automatic logic [AHBW-1:0] merge_bytes(
    input logic [AHBW-1:0]  old_w,
    input logic [AHBW-1:0]  new_w,
    input logic [BYTES-1:0] strb
  );
    logic [AHBW-1:0] r;
    r = old_w;
    for (int i = 0; i < BYTES; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Address-phase decode: word index wraps modulo DEPTH, range check on the full address.
  assign addr_x     = {1'b0, HADDR};
  assign offset     = addr_x - LO;
  assign idx_a      = offset[BSH +: IW];
  assign in_range_a = (addr_x >= LO) && (addr_x < HI);
  assign load_a     = HTRANS[0] ? SQ_LOAD : NS_LOAD;
  assign accept     = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  assign unused_ok  = ^{HSIZE, HBURST, offset[PA_BITS:BSH+IW], offset[BSH-1:0]};

  // Bus outputs follow the registered state directly.
  assign HREADYOUT  = (state != S_WAIT) && (state != S_ERR1);
  assign HRESP      = (state == S_ERR1) || (state == S_ERR2);

  // A beat's write retires at the edge that ends its DATA cycle.
  assign wr_done    = (state == S_DATA) && write_q;

  // Read that enters DATA at this edge: either the waited beat or a zero-wait new beat.
  assign rd_idx     = (state == S_WAIT) ? idx_q   : idx_a;
  assign rd_write   = (state == S_WAIT) ? write_q : HWRITE;
  assign load_rd    = (state_nxt == S_DATA) && !rd_write;
  assign rd_word    = mem[rd_idx];
  assign rd_val     = (wr_done && (idx_q == rd_idx)) ?
                      merge_bytes(rd_word, HWDATA, HWSTRB) : rd_word;

  // Next-state and wait-counter logic.
  always_comb begin
    logic go_new;
    state_nxt = state;
    cnt_nxt   = cnt;
    go_new    = 1'b0;
    unique case (state)
      S_IDLE: go_new = 1'b1;
      S_DATA: go_new = 1'b1;
      S_ERR2: go_new = 1'b1;
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_DATA;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      S_ERR1: state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
    if (go_new) begin
      if (!accept) begin
        state_nxt = S_IDLE;
      end else if (!in_range_a) begin
        state_nxt = S_ERR1;
        cnt_nxt   = 4'd0;
      end else if (load_a == 4'd0) begin
        state_nxt = S_DATA;
        cnt_nxt   = 4'd0;
      end else begin
        state_nxt = S_WAIT;
        cnt_nxt   = load_a;
      end
    end
  end

  // State, captured address phase and read-data register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      HRDATA  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= idx_a;
        write_q <= HWRITE;
      end
      if (load_rd) HRDATA <= rd_val;
    end
  end

  // RAM array: strobed byte update when a write beat retires; reset discards it.
  always_ff @(posedge HCLK) begin
    if (wr_done && !HRESET) mem[idx_q] <= merge_bytes(mem[idx_q], HWDATA, HWSTRB);
  end

endmodule
